// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP add unit among NREQ requesters.
// Optional FPU_ARB_SUB_EN: honour req_sub by flipping the sign of operand 2 at issue.
`timescale 1ns/1ps
module fpu_addsub_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*32-1:0]  req_x1,
  input  logic [NREQ*32-1:0]  req_x2,
  input  logic [NREQ-1:0]     req_sub,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [31:0]         rsp_y,
  output logic                fpu_en,
  output logic [31:0]         fpu_x1,
  output logic [31:0]         fpu_x2,
  input  logic [31:0]         fpu_y,
  output logic                busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    ptr_next;
  logic [IW-1:0]    grant_id;
  logic             grant_any;
  logic             transfer;
  logic [31:0]      x1_sel;
  logic [31:0]      x2_sel;
  logic [31:0]      x2_eff;
  logic [31:0]      x1_reg;
  logic [31:0]      x2_reg;
  logic [NREQ-1:0]  rsp_valid_reg;
  logic [31:0]      rsp_y_reg;

  // Stage 0 is the issue register (aligned with fpu_en); stages 1..LATENCY track the unit.
  logic [LATENCY:0] tag_valid_reg;
  logic [IW-1:0]    tag_id_reg [LATENCY+1];

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = ptr_reg;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rstn && !stall && grant_any) req_ready[grant_id] = 1'b1;
  end

  assign transfer = |req_ready;
  assign ptr_next = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign x1_sel   = req_x1[int'(grant_id)*32 +: 32];
  assign x2_sel   = req_x2[int'(grant_id)*32 +: 32];

`ifdef FPU_ARB_SUB_EN
  assign x2_eff = req_sub[grant_id] ? {~x2_sel[31], x2_sel[30:0]} : x2_sel;
`else
  logic unused_sub;
  assign unused_sub = ^req_sub;
  assign x2_eff     = x2_sel;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_reg          <= '0;
      x1_reg           <= '0;
      x2_reg           <= '0;
      tag_valid_reg[0] <= 1'b0;
      tag_id_reg[0]    <= '0;
    end else begin
      tag_valid_reg[0] <= transfer;
      tag_id_reg[0]    <= grant_id;
      if (transfer) begin
        ptr_reg <= ptr_next;
        x1_reg  <= x1_sel;
        x2_reg  <= x2_eff;
      end
    end
  end

  generate
    for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_id_reg[gi]    <= '0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_id_reg[gi]    <= tag_id_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_reg <= '0;
      rsp_y_reg     <= '0;
    end else begin
      rsp_valid_reg <= '0;
      if (tag_valid_reg[LATENCY]) begin
        rsp_valid_reg[tag_id_reg[LATENCY]] <= 1'b1;
        rsp_y_reg                          <= fpu_y;
      end
    end
  end

  assign fpu_en    = tag_valid_reg[0];
  assign fpu_x1    = x1_reg;
  assign fpu_x2    = x2_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_y     = rsp_y_reg;
  assign busy      = (|tag_valid_reg) | (|rsp_valid_reg);

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Scoreboard bench for fpu_addsub_arbiter with a behavioural LATENCY-deep FP add unit attached.
`timescale 1ns/1ps
module tb_fpu_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_x1;
  logic [NREQ*32-1:0] req_x2;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_y;
  logic              fpu_en;
  logic [31:0]       fpu_x1;
  logic [31:0]       fpu_x2;
  logic [31:0]       fpu_y;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } exp_t;
  exp_t sb[$];

  fpu_addsub_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn), .stall(stall),
    .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .fpu_en(fpu_en), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero only.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Behavioural shared unit: samples fpu_en, result valid LAT cycles later.
  logic [31:0] y_pipe [LAT];
  always @(posedge clk) begin
    y_pipe[0] <= fpu_en ? fadd(fpu_x1, fpu_x2) : 32'h0;
    for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
  end
  assign fpu_y = y_pipe[LAT-1];

  always @(negedge clk) begin
    logic [31:0] x2e;
    exp_t e;
    if (!rstn) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        check("rsp_valid", 64'(rsp_valid), 64'(1) << sb[0].id);
        check("rsp_y", 64'(rsp_y), 64'(sb[0].y));
        void'(sb.pop_front());
      end else if (rsp_valid != '0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          x2e = req_x2[i*32 +: 32];
`ifdef FPU_ARB_SUB_EN
          if (req_sub[i]) x2e = {~x2e[31], x2e[30:0]};
`endif
          e.due = cyc + LAT + 2;
          e.id  = i;
          e.y   = fadd(req_x1[i*32 +: 32], x2e);
          sb.push_back(e);
          $display("issue req%0d x1=%h x2=%h due=%0d", i, req_x1[i*32 +: 32], x2e, e.due);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_x1[i*32 +: 32] = a;
    req_x2[i*32 +: 32] = b;
    req_sub[i]         = s;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_y"}, 64'(rsp_y), 64'd0);
    check({tag, "_fpu_en"}, 64'(fpu_en), 64'd0);
    check({tag, "_fpu_x1"}, 64'(fpu_x1), 64'd0);
    check({tag, "_fpu_x2"}, 64'(fpu_x2), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    stall     = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    next_cycle();
    check("drain", 64'(sb.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn      = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    req_x1    = '0;
    req_x2    = '0;
    req_sub   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    next_cycle();
    rstn = 1'b1;

    // Round robin from ptr 0 with all four requesting.
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b0);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b0);
    set_op(3, 32'h40800000, 32'h3F800000, 1'b0);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(1) << (c % 4));
      next_cycle();
    end
    drain();

    // Single op on req0 (ptr now 0).
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("single_busy", 64'(busy), 64'd1);
    check("single_fpu_en", 64'(fpu_en), 64'd1);
    drain();

    // Back-to-back ops from req2 (ptr now 1).
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      set_op(2, 32'h3F800000 + (32'(c) << 23), 32'h3F800000, 1'b0);
      @(negedge clk);
      check("b2b_grant", 64'(req_ready), 64'h4);
      next_cycle();
    end
    drain();

    // One op from req1 (ptr 3 -> 2), then stall while all request.
    set_op(1, 32'h40000000, 32'h40000000, 1'b0);
    req_valid = 4'b0010;
    @(negedge clk);
    check("pre_stall_grant", 64'(req_ready), 64'h2);
    next_cycle();
    stall     = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_ready", 64'(req_ready), 64'd0);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    check("stall_release_grant", 64'(req_ready), 64'h4);
    next_cycle();
    drain();

    // Subtract request on req1; result depends on build configuration.
    set_op(1, 32'h40400000, 32'h3F800000, 1'b1);
    req_valid = 4'b0010;
    @(negedge clk);
    check("sub_grant", 64'(req_ready), 64'h2);
    next_cycle();
    req_valid = '0;
    req_sub   = '0;
    drain();

    // Reset with three ops in flight.
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b0);
    set_op(3, 32'h40800000, 32'h3F800000, 1'b0);
    req_valid = 4'b1011;
    repeat (3) next_cycle();
    req_valid = '0;
    rstn      = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) next_cycle();
    rstn = 1'b1;
    repeat (10) next_cycle();
    set_op(0, 32'h3F000000, 32'h3FC00000, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("post_reset_grant", 64'(req_ready), 64'h1);
    next_cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
